msrv32_dmem_arbiter: RTL

- Sequences and shares the single AHB-Lite data-memory port between two requesters: the core load/store path and a DMA/debug port.
- Takes word-aligned requests (address, write data, byte write mask, write/read).
- Runs one non-pipelined AHB transfer at a time: one address phase, then a data phase stretched by hready.
- Returns a done pulse with read data to the granted requester; stalls the core pipeline while its access is outstanding.

---
 rtl/msrv32_dmem_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/msrv32_dmem_arbiter.sv
// msrv32_dmem_arbiter: shares one AHB-Lite data port between core and DMA.
// One non-pipelined transfer at a time, with a starvation guard for DMA.
module msrv32_dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        core_req_in,
    input  logic        core_wr_in,
    input  logic [31:0] core_addr_in,
    input  logic [31:0] core_wdata_in,
    input  logic [3:0]  core_mask_in,
    input  logic        dma_req_in,
    input  logic        dma_wr_in,
    input  logic [31:0] dma_addr_in,
    input  logic [31:0] dma_wdata_in,
    input  logic [3:0]  dma_mask_in,
    output logic        core_done_out,
    output logic        dma_done_out,
    output logic [31:0] rdata_out,
    output logic        core_stall_out,
    output logic [31:0] haddr_out,
    output logic [1:0]  htrans_out,
    output logic        hwrite_out,
    output logic [31:0] hwdata_out,
    output logic [3:0]  wr_mask_out,
    input  logic        hready_in,
    input  logic [31:0] hrdata_in
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);
    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_NSEQ = 2'b10;

    state_t      state;
    logic        gnt_dma;
    logic        lat_wr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_mask;
    logic [3:0]  starve_cnt;

    logic        any_req;
    logic        dma_wins;
    logic        xfer_end;
    logic        sel_wr;
    logic [29:0] sel_word;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_mask;
    logic        unused_lsbs;

    // Byte offset bits are never used: every access is a whole word.
    assign unused_lsbs = ^{core_addr_in[1:0], dma_addr_in[1:0]};

    assign any_req  = core_req_in | dma_req_in;
    assign dma_wins = dma_req_in
                    & (~core_req_in | (starve_cnt == LIMIT));
    assign xfer_end = (state == DATA) & hready_in;

    // Winner's request fields, only meaningful at the IDLE grant.
    always_comb begin
        sel_wr    = core_wr_in;
        sel_word  = core_addr_in[31:2];
        sel_wdata = core_wdata_in;
        sel_mask  = core_mask_in;
        if (dma_wins) begin
            sel_wr    = dma_wr_in;
            sel_word  = dma_addr_in[31:2];
            sel_wdata = dma_wdata_in;
            sel_mask  = dma_mask_in;
        end
    end

    // Completion is reported in the same cycle the slave finishes.
    assign core_done_out  = xfer_end & ~gnt_dma;
    assign dma_done_out   = xfer_end & gnt_dma;
    assign rdata_out      = (xfer_end & ~lat_wr) ? hrdata_in : '0;
    assign core_stall_out = core_req_in & ~core_done_out;

    // Transfer sequencer: grant, address phase, data phase.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state       <= IDLE;
            gnt_dma     <= 1'b0;
            lat_wr      <= 1'b0;
            lat_wdata   <= '0;
            lat_mask    <= '0;
            haddr_out   <= '0;
            htrans_out  <= T_IDLE;
            hwrite_out  <= 1'b0;
            hwdata_out  <= '0;
            wr_mask_out <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_dma    <= dma_wins;
                        lat_wr     <= sel_wr;
                        lat_wdata  <= sel_wdata;
                        lat_mask   <= sel_mask;
                        haddr_out  <= {sel_word, 2'b00};
                        htrans_out <= T_NSEQ;
                        hwrite_out <= sel_wr;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (hready_in) begin
                        haddr_out   <= '0;
                        htrans_out  <= T_IDLE;
                        hwrite_out  <= 1'b0;
                        hwdata_out  <= lat_wdata;
                        wr_mask_out <= lat_wr ? lat_mask : 4'b0000;
                        state       <= DATA;
                    end
                end
                DATA: begin
                    if (hready_in) begin
                        hwdata_out  <= '0;
                        wr_mask_out <= '0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    htrans_out <= T_IDLE;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Count how long a pending DMA request has been passed over.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            starve_cnt <= '0;
        end else if (!dma_req_in) begin
            starve_cnt <= '0;
        end else if (state == IDLE && dma_wins) begin
            starve_cnt <= '0;
        end else if (state != IDLE && gnt_dma) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule
